// File: rtl/gpr_file_p.sv
// gpr_file_p: register file with write-first forwarding, overflow status flag
// and a ready/valid serial dump port that streams every register in index order.
module gpr_file_p #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int OVF_REG = 30,
  parameter int OVF_BIT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rr1,
  input  logic [ADDR_W-1:0] rr2,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  input  logic              GPRWr,
  input  logic [ADDR_W-1:0] wr,
  input  logic [DATA_W-1:0] wd,
  input  logic              alu_overflow,
  input  logic              dump_req,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_idx,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_busy
);
  localparam int NREG = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = '1;
  typedef enum logic {IDLE, SEND} state_t;
  state_t state;
  logic [DATA_W-1:0] regs [NREG];
  logic we, ovf;
  logic [ADDR_W-1:0] nxt_idx;
  assign we = GPRWr && wr != '0 && !alu_overflow && !rst;
  assign ovf = GPRWr && alu_overflow && !rst;
  assign nxt_idx = dump_idx + 1'b1;
  // Register 0 is cleared by reset and never written, so it always reads 0.
  assign readData1 = (we && rr1 == wr) ? wd : regs[rr1];
  assign readData2 = (we && rr2 == wr) ? wd : regs[rr2];
  assign dump_busy = state == SEND;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (we) regs[wr] <= wd;
      if (ovf) regs[ADDR_W'(OVF_REG)][OVF_BIT] <= 1'b1;
    end
  end
  // Dump data is taken from pre-edge register contents, so a same-edge write is not seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      dump_valid <= 1'b0;
      dump_idx   <= '0;
      dump_data  <= '0;
    end else if (state == IDLE) begin
      if (dump_req) begin
        state      <= SEND;
        dump_valid <= 1'b1;
        dump_idx   <= '0;
        dump_data  <= '0;
      end
    end else if (dump_valid && dump_ready) begin
      if (dump_idx == LAST) begin
        state      <= IDLE;
        dump_valid <= 1'b0;
      end else begin
        dump_idx  <= nxt_idx;
        dump_data <= regs[nxt_idx];
      end
    end
  end
endmodule

// File: tb/tb_gpr_file_p.sv
// tb_gpr_file_p: directed tests for gpr_file_p covering forwarding, register 0,
// overflow flag, the serial dump handshake, stall, and asynchronous reset.
module tb_gpr_file_p;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rr1, rr2, wr, dump_idx;
  logic [31:0] readData1, readData2, wd, dump_data;
  logic        GPRWr, alu_overflow, dump_req, dump_valid, dump_ready, dump_busy;
  int n_checks = 0;
  int n_fail = 0;

  gpr_file_p dut (
    .clk(clk), .rst(rst), .rr1(rr1), .rr2(rr2),
    .readData1(readData1), .readData2(readData2),
    .GPRWr(GPRWr), .wr(wr), .wd(wd), .alu_overflow(alu_overflow),
    .dump_req(dump_req), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_idx(dump_idx), .dump_data(dump_data), .dump_busy(dump_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
    tick();
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    GPRWr = 1'b1; wr = a; wd = d; alu_overflow = 1'b0;
    tick();
    GPRWr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; GPRWr = 1'b0; wr = '0; wd = '0; alu_overflow = 1'b0;
    dump_req = 1'b0; dump_ready = 1'b0; rr1 = 5'd0; rr2 = 5'd31;
    #2;
    n_checks++;
    if ({dump_valid, dump_busy, dump_idx, dump_data} !== 39'd0) begin
      n_fail++;
      $display("FAIL reset_dump: got v=%b b=%b idx=%0d data=%h, want all 0", dump_valid, dump_busy, dump_idx, dump_data);
    end
    n_checks++;
    if (readData1 !== 32'd0 || readData2 !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_regs: got %h %h, want 0 0", readData1, readData2);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write_forward();
    GPRWr = 1'b1; wr = 5'd5; wd = 32'h12345678; rr1 = 5'd5; rr2 = 5'd6;
    #1;
    n_checks++;
    if (readData1 !== 32'h12345678 || readData2 !== 32'd0) begin
      n_fail++;
      $display("FAIL forward: got %h %h, want 12345678 00000000", readData1, readData2);
    end
    tick();
    GPRWr = 1'b0; wd = 32'h0;
    #1;
    n_checks++;
    if (readData1 !== 32'h12345678) begin
      n_fail++;
      $display("FAIL write_commit: got %h, want 12345678", readData1);
    end
  endtask

  task automatic test_zero_reg();
    GPRWr = 1'b1; wr = 5'd0; wd = 32'hFFFFFFFF; rr1 = 5'd0; rr2 = 5'd0;
    #1;
    n_checks++;
    if (readData1 !== 32'd0) begin
      n_fail++;
      $display("FAIL zero_fwd: got %h, want 00000000", readData1);
    end
    tick();
    GPRWr = 1'b0;
    #1;
    n_checks++;
    if (readData2 !== 32'd0) begin
      n_fail++;
      $display("FAIL zero_write: got %h, want 00000000", readData2);
    end
  endtask

  task automatic test_overflow();
    write_reg(5'd7, 32'hA);
    GPRWr = 1'b1; wr = 5'd7; wd = 32'hB; alu_overflow = 1'b1; rr1 = 5'd7; rr2 = 5'd30;
    #1;
    n_checks++;
    if (readData1 !== 32'hA || readData2 !== 32'd0) begin
      n_fail++;
      $display("FAIL ovf_nofwd: got %h %h, want 0000000a 00000000", readData1, readData2);
    end
    tick();
    GPRWr = 1'b0; alu_overflow = 1'b0;
    #1;
    n_checks++;
    if (readData1 !== 32'hA || readData2 !== 32'h1) begin
      n_fail++;
      $display("FAIL ovf_commit: got %h %h, want 0000000a 00000001", readData1, readData2);
    end
    write_reg(5'd30, 32'hF0);
    GPRWr = 1'b1; wr = 5'd3; wd = 32'h77; alu_overflow = 1'b1; rr1 = 5'd3;
    tick();
    GPRWr = 1'b0; alu_overflow = 1'b0;
    #1;
    n_checks++;
    if (readData1 !== 32'd0 || readData2 !== 32'hF1) begin
      n_fail++;
      $display("FAIL ovf_bits: got %h %h, want 00000000 000000f1", readData1, readData2);
    end
  endtask

  task automatic test_gprwr_off();
    GPRWr = 1'b0; wr = 5'd9; wd = 32'h99; alu_overflow = 1'b1; rr1 = 5'd9; rr2 = 5'd30;
    write_reg(5'd30, 32'h0);
    GPRWr = 1'b0; wr = 5'd9; alu_overflow = 1'b1;
    tick();
    alu_overflow = 1'b0;
    #1;
    n_checks++;
    if (readData1 !== 32'd0 || readData2 !== 32'd0) begin
      n_fail++;
      $display("FAIL wr_off: got %h %h, want 00000000 00000000", readData1, readData2);
    end
  endtask

  task automatic test_dump_full();
    do_reset();
    for (int k = 1; k < 32; k++) write_reg(5'(k), 32'(k));
    dump_ready = 1'b1; dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    n_checks++;
    if (dump_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL dump_busy: got %b, want 1", dump_busy);
    end
    for (int k = 0; k < 32; k++) begin
      n_checks++;
      if (dump_valid !== 1'b1 || dump_idx !== 5'(k) || dump_data !== 32'(k)) begin
        n_fail++;
        $display("FAIL dump_xfer: got v=%b idx=%0d data=%h, want v=1 idx=%0d data=%h", dump_valid, dump_idx, dump_data, k, k);
      end
      dump_req = (k == 5);
      tick();
    end
    dump_req = 1'b0;
    n_checks++;
    if (dump_valid !== 1'b0 || dump_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL dump_end: got v=%b b=%b, want 0 0", dump_valid, dump_busy);
    end
    tick();
    n_checks++;
    if (dump_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL dump_idle: got v=%b, want 0", dump_valid);
    end
  endtask

  task automatic test_dump_stall_and_reset();
    dump_ready = 1'b1; dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    tick(); tick(); tick();
    dump_ready = 1'b0; GPRWr = 1'b1; wr = 5'd3; wd = 32'hDEAD; rr1 = 5'd3;
    tick();
    GPRWr = 1'b0;
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (dump_idx !== 5'd3 || dump_data !== 32'd3 || dump_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL dump_hold: got v=%b idx=%0d data=%h, want v=1 idx=3 data=00000003", dump_valid, dump_idx, dump_data);
      end
      if (c < 3) tick();
    end
    n_checks++;
    if (readData1 !== 32'hDEAD) begin
      n_fail++;
      $display("FAIL read_during_dump: got %h, want 0000dead", readData1);
    end
    dump_ready = 1'b1;
    tick();
    GPRWr = 1'b1; wr = 5'd5; wd = 32'h55;
    n_checks++;
    if (dump_idx !== 5'd4 || dump_data !== 32'd4) begin
      n_fail++;
      $display("FAIL dump_resume: got idx=%0d data=%h, want idx=4 data=00000004", dump_idx, dump_data);
    end
    tick();
    GPRWr = 1'b0;
    n_checks++;
    if (dump_idx !== 5'd5 || dump_data !== 32'd5) begin
      n_fail++;
      $display("FAIL dump_pre_edge: got idx=%0d data=%h, want idx=5 data=00000005", dump_idx, dump_data);
    end
    #3;
    rst = 1'b1; GPRWr = 1'b1; wr = 5'd9; wd = 32'h1; rr1 = 5'd3; rr2 = 5'd5;
    #1;
    n_checks++;
    if (dump_valid !== 1'b0 || dump_busy !== 1'b0 || dump_idx !== 5'd0 || dump_data !== 32'd0) begin
      n_fail++;
      $display("FAIL async_rst_dump: got v=%b b=%b idx=%0d data=%h, want all 0", dump_valid, dump_busy, dump_idx, dump_data);
    end
    n_checks++;
    if (readData1 !== 32'd0 || readData2 !== 32'd0) begin
      n_fail++;
      $display("FAIL async_rst_regs: got %h %h, want 00000000 00000000", readData1, readData2);
    end
    tick();
    rst = 1'b0; GPRWr = 1'b0; rr1 = 5'd9;
    tick(); tick();
    n_checks++;
    if (readData1 !== 32'd0 || dump_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_rst: got rd=%h v=%b, want 00000000 0", readData1, dump_valid);
    end
  endtask

  initial begin
    test_reset();
    test_write_forward();
    test_zero_reg();
    test_overflow();
    test_gprwr_off();
    test_dump_full();
    test_dump_stall_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
